// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between requesters A and B.
// The granted word is sent least-significant byte first, one start strobe per byte.
module tx_arbiter #(
  parameter int NB_DATA = 8,
  parameter int N_BYTES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_req_a,
  input  logic [NB_DATA*N_BYTES-1:0] i_word_a,
  output logic                       o_done_a,
  input  logic                       i_req_b,
  input  logic [NB_DATA*N_BYTES-1:0] i_word_b,
  output logic                       o_done_b,
  output logic                       o_tx_start,
  output logic [NB_DATA-1:0]         o_tx_data,
  input  logic                       i_tx_done_tick,
  output logic                       o_busy,
  output logic                       o_grant
);

  localparam int NB_WORD = NB_DATA * N_BYTES;
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_r;
  logic [NB_WORD-1:0]   buf_r;
  logic [NB_CNT-1:0]    cnt_r;
  logic                 grant_r;
  logic                 last_grant_r;
  logic                 tx_start_r;
  logic [NB_DATA-1:0]   tx_data_r;
  logic                 done_a_r;
  logic                 done_b_r;
  logic                 busy_r;

  logic                 req_any_s;
  logic                 pick_b_s;
  logic [NB_WORD-1:0]   win_word_s;
  logic [NB_WORD-1:0]   shifted_s;

  // Round-robin winner selection; on a tie the previous owner yields.
  always_comb begin
    req_any_s = 1'b0;
    pick_b_s  = 1'b0;
    if (i_req_a && i_req_b) begin
      req_any_s = 1'b1;
      pick_b_s  = ~last_grant_r;
    end else if (i_req_a) begin
      req_any_s = 1'b1;
      pick_b_s  = 1'b0;
    end else if (i_req_b) begin
      req_any_s = 1'b1;
      pick_b_s  = 1'b1;
    end else begin
      req_any_s = 1'b0;
      pick_b_s  = 1'b0;
    end
    win_word_s = pick_b_s ? i_word_b : i_word_a;
    shifted_s  = buf_r >> NB_DATA;
  end

  // Transfer FSM; every output is loaded on the edge that enters the state it belongs to.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r      <= ST_IDLE;
      buf_r        <= '0;
      cnt_r        <= '0;
      grant_r      <= 1'b1;
      last_grant_r <= 1'b1;
      tx_start_r   <= 1'b0;
      tx_data_r    <= '0;
      done_a_r     <= 1'b0;
      done_b_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_start_r <= 1'b0;
          done_a_r   <= 1'b0;
          done_b_r   <= 1'b0;
          if (req_any_s) begin
            buf_r      <= win_word_s;
            cnt_r      <= '0;
            grant_r    <= pick_b_s;
            tx_data_r  <= win_word_s[NB_DATA-1:0];
            tx_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_SEND;
          end else begin
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        ST_SEND: begin
          tx_start_r <= 1'b0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done_tick) begin
            if (cnt_r == LAST_BYTE) begin
              done_a_r <= ~grant_r;
              done_b_r <= grant_r;
              state_r  <= ST_DONE;
            end else begin
              buf_r      <= shifted_s;
              cnt_r      <= cnt_r + NB_CNT'(1);
              tx_data_r  <= shifted_s[NB_DATA-1:0];
              tx_start_r <= 1'b1;
              state_r    <= ST_SEND;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          done_a_r     <= 1'b0;
          done_b_r     <= 1'b0;
          last_grant_r <= grant_r;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          buf_r        <= '0;
          cnt_r        <= '0;
          grant_r      <= 1'b1;
          last_grant_r <= 1'b1;
          tx_start_r   <= 1'b0;
          tx_data_r    <= '0;
          done_a_r     <= 1'b0;
          done_b_r     <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_start = tx_start_r;
  assign o_tx_data  = tx_data_r;
  assign o_done_a   = done_a_r;
  assign o_done_b   = done_b_r;
  assign o_busy     = busy_r;
  assign o_grant    = grant_r;

endmodule
